// File: rtl/branch_resolve_predict_if.sv
// EX-stage branch resolution / prediction bus: fetch lookup, EX resolve inputs,
// flush outputs and statistics.
interface branch_resolve_predict_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             stall;
    logic [4:0]       ex_opcode;
    logic [1:0]       ex_flags;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic             pc_branch_sel_out;
    logic             mispredict;
    logic             clr_stats;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output lookup_pc, ex_valid, stall, ex_opcode, ex_flags, ex_pc,
               ex_pred_taken, clr_stats,
        input  pred_taken, pc_branch_sel_out, mispredict, branch_cnt, mispred_cnt
    );

    modport slave (
        input  lookup_pc, ex_valid, stall, ex_opcode, ex_flags, ex_pc,
               ex_pred_taken, clr_stats,
        output pred_taken, pc_branch_sel_out, mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_predict.sv
// Branch resolution for EX with a PC-indexed table of 2-bit saturating
// predictors, a registered flush pulse and saturating statistics.
module bp_ctr_cell #(
    parameter logic [1:0] CTR_RESET = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_upd,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);
    typedef enum logic [1:0] {
        S_SNT = 2'b00,
        S_WNT = 2'b01,
        S_WT  = 2'b10,
        S_ST  = 2'b11
    } state_e;

    state_e r_state;
    state_e w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= state_e'(CTR_RESET);
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_upd) begin
            unique case (r_state)
                S_SNT: w_next = i_taken ? S_WNT : S_SNT;
                S_WNT: w_next = i_taken ? S_WT  : S_SNT;
                S_WT:  w_next = i_taken ? S_ST  : S_WNT;
                S_ST:  w_next = i_taken ? S_ST  : S_WT;
                default: w_next = r_state;
            endcase
        end
    end

    assign o_ctr = r_state;
endmodule

module branch_resolve_predict #(
    parameter int         PC_W      = 16,
    parameter int         IDX_W     = 4,
    parameter logic [1:0] CTR_RESET = 2'b01,
    parameter int         CNT_W     = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    branch_resolve_predict_if.slave bus
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [4:0] OP_BEQ = 5'b10011;
    localparam logic [4:0] OP_BLT = 5'b10100;
    localparam logic [4:0] OP_BGT = 5'b10101;
    localparam logic [4:0] OP_BNE = 5'b10110;

    logic                  w_is_br;
    logic                  w_taken;
    logic                  w_accept;
    logic                  w_mis;
    logic [IDX_W-1:0]      w_upd_idx;
    logic [IDX_W-1:0]      w_lk_idx;
    logic [DEPTH-1:0][1:0] w_ctr;

    logic             r_sel;
    logic             r_mis;
    logic [CNT_W-1:0] r_bcnt;
    logic [CNT_W-1:0] r_mcnt;

    // Each opcode looks at exactly one flag bit so the other can be X.
    always_comb begin
        w_is_br = 1'b1;
        w_taken = 1'b0;
        case (bus.ex_opcode)
            OP_BEQ:  w_taken =  bus.ex_flags[1];
            OP_BNE:  w_taken = ~bus.ex_flags[1];
            OP_BLT:  w_taken =  bus.ex_flags[0];
            OP_BGT:  w_taken = ~bus.ex_flags[0];
            default: w_is_br = 1'b0;
        endcase
    end

    assign w_accept  = bus.ex_valid & ~bus.stall & w_is_br;
    assign w_mis     = w_taken ^ bus.ex_pred_taken;
    assign w_upd_idx = bus.ex_pc[IDX_W-1:0];
    assign w_lk_idx  = bus.lookup_pc[IDX_W-1:0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        bp_ctr_cell #(.CTR_RESET(CTR_RESET)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_upd   (w_accept && (w_upd_idx == IDX_W'(g))),
            .i_taken (w_taken),
            .o_ctr   (w_ctr[g])
        );
    end

    // Read is the registered entry state: a same-cycle update is not bypassed.
    assign bus.pred_taken = w_ctr[w_lk_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= 1'b0;
            r_mis <= 1'b0;
        end else begin
            r_sel <= w_accept & w_taken;
            r_mis <= w_accept & w_mis;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
            r_mcnt <= '0;
        end else if (bus.clr_stats) begin
            r_bcnt <= '0;
            r_mcnt <= '0;
        end else if (w_accept) begin
            if (r_bcnt != '1)          r_bcnt <= r_bcnt + 1'b1;
            if (w_mis && r_mcnt != '1) r_mcnt <= r_mcnt + 1'b1;
        end
    end

    assign bus.pc_branch_sel_out = r_sel;
    assign bus.mispredict        = r_mis;
    assign bus.branch_cnt        = r_bcnt;
    assign bus.mispred_cnt       = r_mcnt;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Bench for branch_resolve_predict: vector table, directed corner sequences and
// random traffic against a table/counter model; a CNT_W=2 copy shows saturation.
module tb_branch_resolve_predict;
    localparam logic [4:0] BEQ = 5'b10011, BLT = 5'b10100, BGT = 5'b10101, BNE = 5'b10110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_predict_if #(.PC_W(16), .CNT_W(16)) bi ();
    branch_resolve_predict_if #(.PC_W(16), .CNT_W(2))  si ();

    branch_resolve_predict #(.PC_W(16), .IDX_W(4), .CTR_RESET(2'b01), .CNT_W(16))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bi.slave));
    branch_resolve_predict #(.PC_W(16), .IDX_W(4), .CTR_RESET(2'b01), .CNT_W(2))
        u_small (.clk(clk), .rst_n(rst_n), .bus(si.slave));

    logic [15:0] t_lookup = '0, t_pc = '0;
    logic        t_valid = 1'b0, t_stall = 1'b0, t_pred = 1'b0, t_clr = 1'b0;
    logic [4:0]  t_op = '0;
    logic [1:0]  t_flags = '0;

    assign bi.lookup_pc = t_lookup;     assign si.lookup_pc = t_lookup;
    assign bi.ex_valid = t_valid;       assign si.ex_valid = t_valid;
    assign bi.stall = t_stall;          assign si.stall = t_stall;
    assign bi.ex_opcode = t_op;         assign si.ex_opcode = t_op;
    assign bi.ex_flags = t_flags;       assign si.ex_flags = t_flags;
    assign bi.ex_pc = t_pc;             assign si.ex_pc = t_pc;
    assign bi.ex_pred_taken = t_pred;   assign si.ex_pred_taken = t_pred;
    assign bi.clr_stats = t_clr;        assign si.clr_stats = t_clr;

    int n_chk = 0, n_fail = 0;
    int m_tab[16];
    int m_b = 0, m_m = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        foreach (m_tab[i]) m_tab[i] = 1;
        m_b = 0;
        m_m = 0;
    endtask

    // One cycle: apply inputs, check combinational prediction, clock, check outputs.
    task automatic step(input logic [4:0] op, input logic [1:0] fl, input logic [15:0] pc,
                        input bit pred, input bit vld, input bit stl, input bit clr,
                        input logic [15:0] lk);
        bit is_br, tk, acc;
        int idx;
        t_op = op; t_flags = fl; t_pc = pc; t_pred = pred;
        t_valid = vld; t_stall = stl; t_clr = clr; t_lookup = lk;
        #1;
        chk("pred_taken", bi.pred_taken, (m_tab[lk[3:0]] >= 2) ? 1 : 0);
        is_br = 1; tk = 0;
        case (op)
            BEQ: tk = (fl[1] == 1'b1);
            BNE: tk = (fl[1] == 1'b0);
            BLT: tk = (fl[0] == 1'b1);
            BGT: tk = (fl[0] == 1'b0);
            default: is_br = 0;
        endcase
        acc = vld && !stl && is_br;
        if (acc) begin
            idx = int'(pc[3:0]);
            m_tab[idx] = tk ? ((m_tab[idx] < 3) ? m_tab[idx] + 1 : 3)
                            : ((m_tab[idx] > 0) ? m_tab[idx] - 1 : 0);
            m_b++;
            if (tk != pred) m_m++;
        end
        if (clr) begin m_b = 0; m_m = 0; end
        @(posedge clk); #1;
        chk("pc_branch_sel_out", bi.pc_branch_sel_out, (acc && tk) ? 1 : 0);
        chk("mispredict", bi.mispredict, (acc && tk != pred) ? 1 : 0);
        chk("branch_cnt", bi.branch_cnt, sat(m_b, 65535));
        chk("mispred_cnt", bi.mispred_cnt, sat(m_m, 65535));
        chk("small_branch_cnt", si.branch_cnt, sat(m_b, 3));
        chk("small_mispred_cnt", si.mispred_cnt, sat(m_m, 3));
    endtask

    task automatic idle();
        step(5'b00000, 2'b00, 16'h0, 0, 0, 0, 0, t_lookup);
    endtask

    typedef struct {
        logic [4:0] op;
        logic [1:0] fl;
        bit         exp_taken;
    } vec_t;

    initial begin
        vec_t vt[$];
        model_reset();

        // Reset state
        #12;
        chk("rst_sel", bi.pc_branch_sel_out, 0);
        chk("rst_mis", bi.mispredict, 0);
        chk("rst_bcnt", bi.branch_cnt, 0);
        chk("rst_mcnt", bi.mispred_cnt, 0);
        chk("rst_pred", bi.pred_taken, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First mispredicted BEQ at 0x0003
        step(BEQ, 2'b10, 16'h0003, 0, 1, 0, 0, 16'h0003);
        chk("first_sel", bi.pc_branch_sel_out, 1);
        chk("first_mis", bi.mispredict, 1);
        chk("first_bcnt", bi.branch_cnt, 1);
        chk("first_mcnt", bi.mispred_cnt, 1);
        chk("first_pred_after", bi.pred_taken, 1);

        // Truth table, prediction always matches so no mispredicts
        vt = '{
            '{BEQ, 2'b00, 0}, '{BEQ, 2'b01, 0}, '{BEQ, 2'b10, 1}, '{BEQ, 2'b11, 1},
            '{BNE, 2'b00, 1}, '{BNE, 2'b01, 1}, '{BNE, 2'b10, 0}, '{BNE, 2'b11, 0},
            '{BLT, 2'b00, 0}, '{BLT, 2'b01, 1}, '{BLT, 2'b10, 0}, '{BLT, 2'b11, 1},
            '{BGT, 2'b00, 1}, '{BGT, 2'b01, 0}, '{BGT, 2'b10, 1}, '{BGT, 2'b11, 0},
            '{5'b00001, 2'b10, 0}
        };
        foreach (vt[i]) begin
            step(vt[i].op, vt[i].fl, 16'h000A, vt[i].exp_taken, 1, 0, 0, 16'h000A);
            chk("tt_sel", bi.pc_branch_sel_out, vt[i].exp_taken);
            chk("tt_mis", bi.mispredict, 0);
        end
        chk("tt_bcnt", bi.branch_cnt, 17);

        // Saturation on entry 5
        for (int i = 0; i < 5; i++) step(BNE, 2'b00, 16'h0015, 1, 1, 0, 0, 16'h0005);
        chk("sat_hi_pred", bi.pred_taken, 1);
        step(BNE, 2'b10, 16'h0015, 1, 1, 0, 0, 16'h0005);
        chk("sat_one_nt_pred", bi.pred_taken, 1);
        step(BNE, 2'b10, 16'h0015, 1, 1, 0, 0, 16'h0005);
        step(BNE, 2'b10, 16'h0015, 0, 1, 0, 0, 16'h0005);
        chk("sat_lo_pred", bi.pred_taken, 0);

        // Stall blocks resolution, release resolves
        step(BLT, 2'b01, 16'h0009, 1, 1, 1, 0, 16'h0009);
        chk("stall_sel", bi.pc_branch_sel_out, 0);
        chk("stall_pred_unchanged", bi.pred_taken, 0);
        step(BLT, 2'b01, 16'h0009, 1, 1, 0, 0, 16'h0009);
        chk("unstall_sel", bi.pc_branch_sel_out, 1);

        // Same-cycle read/write of entry 2 (at 01)
        step(BEQ, 2'b10, 16'h0002, 1, 1, 0, 0, 16'h0002);
        chk("same_cycle_next", bi.pred_taken, 1);

        // clr_stats wins over a simultaneous mispredict
        step(BEQ, 2'b10, 16'h0004, 0, 1, 0, 1, 16'h0004);
        chk("clr_bcnt", bi.branch_cnt, 0);
        chk("clr_mcnt", bi.mispred_cnt, 0);
        chk("clr_mis_pulse", bi.mispredict, 1);

        // CNT_W=2 copy holds at 3
        for (int i = 0; i < 4; i++) step(BGT, 2'b00, 16'h0001, 1, 1, 0, 0, 16'h0001);
        chk("small_sat", si.branch_cnt, 3);
        chk("big_four", bi.branch_cnt, 4);

        // Train entry 7, then async reset mid-cycle
        for (int i = 0; i < 3; i++) step(BEQ, 2'b10, 16'h0007, 0, 1, 0, 0, 16'h0007);
        chk("trained_pred", bi.pred_taken, 1);
        step(BEQ, 2'b10, 16'h0007, 0, 1, 0, 0, 16'h0007);
        t_valid = 0; t_clr = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", bi.pc_branch_sel_out, 0);
        chk("arst_mis", bi.mispredict, 0);
        chk("arst_bcnt", bi.branch_cnt, 0);
        chk("arst_mcnt", bi.mispred_cnt, 0);
        chk("arst_pred", bi.pred_taken, 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        // Every entry should be weak-NT: one taken flips its prediction
        for (int i = 0; i < 16; i++) begin
            step(BEQ, 2'b10, 16'(i), 1, 1, 0, 0, 16'(i));
            chk("post_rst_entry", bi.pred_taken, 1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            logic [15:0] pc, lk;
            case ($urandom_range(0, 5))
                0: op = BEQ;
                1: op = BNE;
                2: op = BLT;
                3: op = BGT;
                default: op = 5'($urandom);
            endcase
            pc = 16'($urandom);
            lk = ($urandom_range(0, 3) == 0) ? pc : 16'($urandom);
            step(op, 2'($urandom), pc, 1'($urandom), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0), lk);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
- Next-generation branch resolution block for the EX stage.
- Resolves BEQ/BNE/BLT/BGT from the ALU flags and registers the taken select for the PC mux. This keeps the existing one-cycle timing.
- Adds a parametrised table of 2-bit saturating predictors indexed by PC low bits, a registered mispredict pulse for pipeline flush, and saturating branch/mispredict statistics counters.

Parameters:
- PC_W, 16, width of PC inputs.
- IDX_W, 4, predictor index width; table depth = 2**IDX_W entries, indexed by pc[IDX_W-1:0]; 1 <= IDX_W <= PC_W.
- CTR_RESET, 2'b01, reset value of every predictor entry (weakly not-taken).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_pc  in  PC_W  fetch-stage PC for prediction.
- pred_taken  out  1  combinational prediction = table[lookup_pc[IDX_W-1:0]][1].
- ex_valid  in  1  EX-stage instruction valid.
- stall  in  1  pipeline stall; when 1, EX input is ignored for this cycle.
- ex_opcode  in  5  EX-stage opcode.
- ex_flags  in  2  ALU flags; [1] = equal/zero, [0] = less-than.
- ex_pc  in  PC_W  PC of the EX-stage instruction.
- ex_pred_taken  in  1  prediction carried down from fetch for this instruction.
- pc_branch_sel_out  out  1  registered resolved-taken.
- mispredict  out  1  registered one-cycle flush request.
- clr_stats  in  1  synchronous clear of statistics counters.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispred_cnt  out  CNT_W  mispredictions, saturating.

Behaviour:
- Opcodes: BEQ=5'b10011, BLT=5'b10100, BGT=5'b10101, BNE=5'b10110. Any other value is a non-branch.
- Taken rules:
  - BEQ: flags[1]==1.
  - BNE: flags[1]==0.
  - BLT: flags[0]==1.
  - BGT: flags[0]==0.
  - The unused flag bit is don't-care. X on the don't-care bit must not affect the result.
- accept = ex_valid & ~stall & (opcode is a branch).
- On a clock edge with accept=1:
  - pc_branch_sel_out <= taken.
  - mispredict <= (taken != ex_pred_taken).
  - Predictor entry ex_pc[IDX_W-1:0] updates: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
  - branch_cnt increments, saturating at all-ones.
  - mispred_cnt increments on mispredict, saturating at all-ones.
- On a clock edge with accept=0: pc_branch_sel_out <= 0 and mispredict <= 0. There is no table or statistics update. Outputs are therefore single-cycle pulses, never held across stall.
- Latency: EX inputs to pc_branch_sel_out/mispredict is 1 cycle. lookup_pc to pred_taken is 0 cycles (combinational).
- Same-cycle read/write of one entry: pred_taken returns the pre-update value. There is no bypass; the new value is visible from the next cycle.
- Predictor entry FSM: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is bit[1].
- clr_stats=1: both statistics counters go to 0 on the edge. This overrides a simultaneous increment. The table and outputs are unaffected.
- Reset (asynchronous, any time including mid-update):
  - pc_branch_sel_out=0, mispredict=0.
  - branch_cnt=0, mispred_cnt=0.
  - All table entries = CTR_RESET.
  - pred_taken reflects CTR_RESET[1] immediately.
- Aliasing: PCs with equal low IDX_W bits share an entry. This is intended.

Test Plan:
- Reset, then lookup_pc=0x0003 -> pred_taken=0. Then BEQ ex_pc=0x0003, flags=2'b10, ex_pred_taken=0 -> next cycle pc_branch_sel_out=1, mispredict=1, branch_cnt=1, mispred_cnt=1; afterwards pred_taken at 0x0003 = 1 (entry 10).
- Truth table: all four opcodes x flags 00/01/10/11 with ex_pred_taken matching the expected result -> pc_branch_sel_out per the rules, mispredict=0 throughout. Non-branch opcode 5'b00001 with flags=2'b10 -> both outputs 0, branch_cnt unchanged.
- Saturation: five taken BNE (flags=2'b00) at ex_pc=0x0015 -> entry 5 reaches 11 and stays there. One not-taken -> entry 10, pred_taken still 1. Two more not-taken -> 00, pred_taken=0.
- Stall: taken BLT with ex_valid=1, stall=1 -> outputs 0, table and branch_cnt unchanged. Deassert stall -> resolves next cycle.
- Same cycle: lookup_pc=ex_pc=0x0002, taken update on entry at 01 -> pred_taken=0 that cycle, 1 the next cycle. Also clr_stats=1 alongside an accepted mispredict -> both counters 0.
- Async reset: assert rst_n=0 mid-cycle after training entries -> outputs 0 immediately, counters 0, all entries back to CTR_RESET. With CNT_W=2, four branches -> branch_cnt holds at 3.
